// File: rtl/pri_stagger_seq.sv
// Staggered-PRI sequencer: presents one (pw, pri) table entry per pulse repetition interval.
// Optional PRI jitter (16-bit LFSR) enabled by defining PRI_JITTER_EN.
module pri_stagger_seq #(
  parameter int DEPTH = 8,
  parameter int PW_W  = 4,
  parameter int PRI_W = 8,
  parameter int CPI_W = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PW_W-1:0]  wr_pw,
  input  logic [PRI_W-1:0] wr_pri,
  input  logic [AW:0]      seq_len,
  input  logic [CPI_W-1:0] num_cpi,
  input  logic             start,
  input  logic             abort,
  output logic [PW_W-1:0]  pw_out,
  output logic [PRI_W-1:0] pri_out,
  output logic             period_start,
  output logic [AW-1:0]    entry_idx,
  output logic             busy,
  output logic             done
);

  localparam int CW = (PW_W > PRI_W) ? PW_W : PRI_W;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [PW_W-1:0]  pw;
    logic [PRI_W-1:0] pri;
  } entry_t;

  state_t           state;
  entry_t           tbl [DEPTH];
  logic [PRI_W-1:0] cnt;
  logic [CPI_W-1:0] cpi_cnt;
  logic [CPI_W-1:0] num_cpi_r;
  logic [AW:0]      last_idx;

  logic [AW:0]      len_c;
  logic [AW:0]      last_c;
  logic             wrap;
  logic [AW-1:0]    nxt_idx;
  logic [CPI_W-1:0] cpi_nxt;
  logic             finish;
  logic [AW-1:0]    ld_idx;
  entry_t           ld_e;
  logic [PRI_W-1:0] ld_pri;
  logic [PW_W-1:0]  ld_pw;

  // Table is deliberately not reset; it only changes outside RUN.
  always_ff @(posedge clk) begin
    if (wr_en && state != RUN)
      tbl[wr_addr] <= {wr_pw, wr_pri};
  end

  always_comb begin
    len_c = seq_len;
    if (seq_len == '0)         len_c = (AW+1)'(1);
    else if (seq_len > DEPTH_L) len_c = DEPTH_L;
    last_c = len_c - (AW+1)'(1);
  end

  assign wrap    = ({1'b0, entry_idx} == last_idx);
  assign nxt_idx = wrap ? '0 : entry_idx + AW'(1);
  assign cpi_nxt = cpi_cnt + CPI_W'(1);
  assign finish  = wrap && (num_cpi_r != '0) && (cpi_nxt == num_cpi_r);
  assign ld_idx  = (state == RUN) ? nxt_idx : '0;
  assign ld_e    = tbl[ld_idx];

`ifdef PRI_JITTER_EN
  logic [15:0]    lfsr;
  logic           lfsr_fb;
  logic [PRI_W:0] jit_sum;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign jit_sum = {1'b0, ld_e.pri} + (PRI_W+1)'(lfsr[1:0]);
  // Saturate instead of wrapping so a near-max PRI never collapses to a short period.
  assign ld_pri  = jit_sum[PRI_W] ? '1 : jit_sum[PRI_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               lfsr <= 16'hACE1;
    else if (period_start) lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  assign ld_pri = ld_e.pri;
`endif

  // Clamp width to PRI so every period has at least one low cycle.
  always_comb begin
    ld_pw = ld_e.pw;
    if (CW'(ld_e.pw) > CW'(ld_pri))
      ld_pw = PW_W'(ld_pri);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pw_out       <= '0;
      pri_out      <= '0;
      period_start <= 1'b0;
      entry_idx    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cnt          <= '0;
      cpi_cnt      <= '0;
      num_cpi_r    <= '0;
      last_idx     <= '0;
    end else begin
      period_start <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state        <= RUN;
            busy         <= 1'b1;
            period_start <= 1'b1;
            entry_idx    <= '0;
            cnt          <= '0;
            cpi_cnt      <= '0;
            num_cpi_r    <= num_cpi;
            last_idx     <= last_c;
            pw_out       <= ld_pw;
            pri_out      <= ld_pri;
          end
        end
        RUN: begin
          if (abort || (cnt == pri_out && finish)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pw_out    <= '0;
            pri_out   <= '0;
            entry_idx <= '0;
            cnt       <= '0;
          end else if (cnt == pri_out) begin
            cnt          <= '0;
            entry_idx    <= nxt_idx;
            period_start <= 1'b1;
            pw_out       <= ld_pw;
            pri_out      <= ld_pri;
            if (wrap) cpi_cnt <= cpi_nxt;
          end else begin
            cnt <= cnt + PRI_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pri_stagger_seq.sv
// Bench for pri_stagger_seq: scoreboard of expected periods popped on each period_start.
module tb_pri_stagger_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_pw = '0;
  logic [7:0] wr_pri = '0;
  logic [3:0] seq_len = '0;
  logic [7:0] num_cpi = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] pw_out;
  logic [7:0] pri_out;
  logic       period_start;
  logic [2:0] entry_idx;
  logic       busy;
  logic       done;

  pri_stagger_seq #(.DEPTH(8), .PW_W(4), .PRI_W(8), .CPI_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pw(wr_pw),
    .wr_pri(wr_pri), .seq_len(seq_len), .num_cpi(num_cpi), .start(start),
    .abort(abort), .pw_out(pw_out), .pri_out(pri_out), .period_start(period_start),
    .entry_idx(entry_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pw;
    int pri;
    int idx;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_pass = 0;
  int   n_total = 0;
  int   plen = 0;
  int   busy_cnt = 0;
  bit   have_prev = 0;

  task automatic push(input int pw, input int pri, input int idx);
    exp_t e;
    e.pw  = (pw > pri) ? pri : pw;
    e.pri = pri;
    e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic sb_clear();
    sb.delete();
    have_prev = 0;
    plen = 0;
    busy_cnt = 0;
  endtask

  // One clock of scoreboard: pop on period_start, check hold and period length otherwise.
  task automatic step();
    @(negedge clk);
    if (busy) busy_cnt++;
    if (period_start) begin
      if (have_prev) begin
        n_total++;
        if (plen !== cur.pri + 1)
          $display("FAIL period_len: got %0d want %0d", plen, cur.pri + 1);
        else n_pass++;
      end
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_empty: got period_start idx=%0d want none", entry_idx);
      end else begin
        cur = sb.pop_front();
        if (pw_out !== cur.pw[3:0] || pri_out !== cur.pri[7:0] || entry_idx !== cur.idx[2:0])
          $display("FAIL entry: got pw=%0d pri=%0d idx=%0d want pw=%0d pri=%0d idx=%0d",
                   pw_out, pri_out, entry_idx, cur.pw, cur.pri, cur.idx);
        else n_pass++;
      end
      have_prev = 1;
      plen = 1;
    end else if (busy) begin
      plen++;
      n_total++;
      if (pw_out !== cur.pw[3:0] || pri_out !== cur.pri[7:0])
        $display("FAIL hold: got pw=%0d pri=%0d want pw=%0d pri=%0d", pw_out, pri_out, cur.pw, cur.pri);
      else n_pass++;
    end
  endtask

  task automatic wr(input int addr, input int pw, input int pri);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr[2:0]; wr_pw = pw[3:0]; wr_pri = pri[7:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives start and checks the one-cycle latency to the first period_start.
  task automatic kick(input string name);
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
    n_total++;
    if (period_start !== 1'b1 || busy !== 1'b1)
      $display("FAIL %s_first: got ps=%b busy=%b want 1 1", name, period_start, busy);
    else n_pass++;
  endtask

  task automatic run_to_done(input string name, input int max_cyc, input int exp_busy);
    bit seen = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (done) seen = 1;
    end
    n_total++;
    if (!seen) $display("FAIL %s_timeout: got no done want done in %0d", name, max_cyc);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || plen !== cur.pri + 1)
      $display("FAIL %s_done: got busy=%b last_len=%0d want 0 %0d", name, busy, plen, cur.pri + 1);
    else n_pass++;
    n_total++;
    if (busy_cnt !== exp_busy || sb.size() != 0)
      $display("FAIL %s_busy: got busy_cycles=%0d left=%0d want %0d 0", name, busy_cnt, sb.size(), exp_busy);
    else n_pass++;
    step();
    n_total++;
    if (done !== 1'b0 || pw_out !== 4'd0 || pri_out !== 8'd0)
      $display("FAIL %s_idle: got done=%b pw=%0d pri=%0d want 0 0 0", name, done, pw_out, pri_out);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if ({pw_out, pri_out, period_start, entry_idx, busy, done} !== '0)
      $display("FAIL reset: got pw=%0d pri=%0d ps=%b idx=%0d busy=%b done=%b want all 0",
               pw_out, pri_out, period_start, entry_idx, busy, done);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    sb_clear();
    wr(0, 3, 9); wr(1, 2, 14); wr(2, 5, 19);
    seq_len = 4'd3; num_cpi = 8'd2;
    for (int c = 0; c < 2; c++) begin
      push(3, 9, 0); push(2, 14, 1); push(5, 19, 2);
    end
    kick("basic");
    run_to_done("basic", 200, 90);
  endtask

  task automatic test_clamp();
    sb_clear();
    wr(0, 15, 4); wr(1, 7, 0);
    seq_len = 4'd2; num_cpi = 8'd2;
    for (int c = 0; c < 2; c++) begin
      push(15, 4, 0); push(7, 0, 1);
    end
    kick("clamp");
    run_to_done("clamp", 50, 12);
  endtask

  task automatic test_seq_len_edges();
    // seq_len 0 acts as 1; seq_len above DEPTH clamps to DEPTH.
    sb_clear();
    for (int a = 0; a < 8; a++) wr(a, 1, a + 1);
    seq_len = 4'd0; num_cpi = 8'd2;
    push(1, 1, 0); push(1, 1, 0);
    kick("len0");
    run_to_done("len0", 20, 4);
    sb_clear();
    seq_len = 4'd12; num_cpi = 8'd1;
    for (int a = 0; a < 8; a++) push(1, a + 1, a);
    kick("lenmax");
    run_to_done("lenmax", 100, 44);
  endtask

  task automatic test_continuous_abort();
    bit saw_done = 0;
    sb_clear();
    wr(0, 1, 3); wr(1, 2, 5); wr(2, 3, 7);
    seq_len = 4'd3; num_cpi = 8'd0;
    for (int c = 0; c < 60; c++) begin
      push(1, 3, 0); push(2, 5, 1); push(3, 7, 2);
    end
    kick("cont");
    for (int i = 0; i < 1000; i++) begin
      step();
      if (done) saw_done = 1;
    end
    if (period_start) step();
    n_total++;
    if (saw_done || busy !== 1'b1)
      $display("FAIL cont_run: got done_seen=%b busy=%b want 0 1", saw_done, busy);
    else n_pass++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL abort_done: got done=%b busy=%b want 1 0", done, busy);
    else n_pass++;
    step();
    n_total++;
    if (done !== 1'b0 || pw_out !== 4'd0 || pri_out !== 8'd0 || period_start !== 1'b0)
      $display("FAIL abort_after: got done=%b pw=%0d pri=%0d ps=%b want 0 0 0 0",
               done, pw_out, pri_out, period_start);
    else n_pass++;
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || period_start !== 1'b0)
      $display("FAIL idle_abort: got busy=%b done=%b ps=%b want 0 0 0", busy, done, period_start);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_abort2: got done=%b busy=%b want 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_wr_during_run();
    sb_clear();
    wr(0, 2, 5); wr(1, 3, 6);
    seq_len = 4'd2; num_cpi = 8'd2;
    for (int c = 0; c < 2; c++) begin
      push(2, 5, 0); push(3, 6, 1);
    end
    kick("wrrun");
    step(); step();
    wr_en = 1'b1; wr_addr = 3'd0; wr_pw = 4'd9; wr_pri = 8'd1;
    step();
    wr_en = 1'b0;
    run_to_done("wrrun", 60, 26);
    sb_clear();
    num_cpi = 8'd1;
    push(2, 5, 0); push(3, 6, 1);
    kick("wrrun2");
    run_to_done("wrrun2", 40, 13);
  endtask

  task automatic test_reset_mid();
    sb_clear();
    seq_len = 4'd2; num_cpi = 8'd0;
    for (int c = 0; c < 4; c++) begin
      push(2, 5, 0); push(3, 6, 1);
    end
    kick("rstmid");
    for (int i = 0; i < 8; i++) step();
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({pw_out, pri_out, period_start, entry_idx, busy, done} !== '0)
      $display("FAIL rst_async: got pw=%0d pri=%0d ps=%b idx=%0d busy=%b done=%b want all 0",
               pw_out, pri_out, period_start, entry_idx, busy, done);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_nodone: got done=%b busy=%b want 0 0", done, busy);
    else n_pass++;
    rst = 1'b0;
    sb_clear();
    num_cpi = 8'd1;
    push(2, 5, 0); push(3, 6, 1);
    kick("rstnew");
    run_to_done("rstnew", 40, 13);
  endtask

`ifdef PRI_JITTER_EN
  task automatic test_jitter();
    logic [15:0] l;
    int          p;
    sb_clear();
    do_reset();
    wr(0, 3, 253);
    seq_len = 4'd1; num_cpi = 8'd6;
    l = 16'hACE1;
    for (int k = 0; k < 6; k++) begin
      p = 253 + int'(l[1:0]);
      if (p > 255) p = 255;
      push(3, p, 0);
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    kick("jit");
    n_total++;
    if (pri_out < 8'd253)
      $display("FAIL jit_range: got pri=%0d want 253..255", pri_out);
    else n_pass++;
    run_to_done("jit", 2000, busy_cnt_total());
  endtask

  function automatic int busy_cnt_total();
    int s = 0;
    foreach (sb[i]) s += sb[i].pri + 1;
    return s + cur.pri + 1;
  endfunction
`endif

  initial begin
    test_reset();
`ifdef PRI_JITTER_EN
    test_jitter();
`else
    test_basic();
    test_clamp();
    test_seq_len_edges();
    test_start_abort_idle();
    test_continuous_abort();
    test_wr_during_run();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
